// File: rtl/seq_detector_param.sv
// seq_detector_param: parametrised Moore serial pattern detector.
// The state register holds the length of the pattern prefix matched so far.
// A KMP-style next-state function is evaluated over PATTERN at elaboration.
// Optional saturating hit counter is built only when SEQ_DET_COUNT_EN is defined;
// otherwise match_count is tied to zero.
module seq_detector_param #(
    parameter int unsigned    N       = 4,
    parameter logic [N-1:0]   PATTERN = 4'b1011,
    parameter bit             OVERLAP = 1'b1,
    parameter int unsigned    CW      = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     clear,
    input  logic                     en,
    input  logic                     w,
    output logic                     z,
    output logic [$clog2(N+1)-1:0]   state,
    output logic [CW-1:0]            match_count
);

    localparam int unsigned   SW       = $clog2(N+1);
    localparam logic [SW-1:0] ST_EMPTY = '0;
    localparam logic [SW-1:0] ST_MATCH = SW'(N);

    logic [SW-1:0] state_q;
    logic [SW-1:0] state_d;

    // Bit i of the pattern in arrival order (bit 0 is PATTERN[N-1]).
    function automatic logic pat_bit(input int unsigned i);
        logic [N-1:0] shifted;
        shifted = PATTERN >> (N - 1 - i);
        return shifted[0];
    endfunction

    // Longest pattern prefix that is a suffix of (prefix of length k, then b).
    // Ascending j with last-hit-wins yields the longest match.
    function automatic logic [SW-1:0] kmp_next(input int unsigned k, input logic b);
        logic [SW-1:0] best;
        logic          ok;
        logic          sbit;
        int unsigned   idx;
        best = ST_EMPTY;
        for (int unsigned j = 1; j <= N; j++) begin
            if (j <= k + 1) begin
                ok = 1'b1;
                for (int unsigned i = 0; i < N; i++) begin
                    if (i < j) begin
                        idx  = k + 1 - j + i;
                        sbit = (idx == k) ? b : pat_bit(idx);
                        if (pat_bit(i) != sbit) begin
                            ok = 1'b0;
                        end
                    end
                end
                if (ok) begin
                    best = SW'(j);
                end
            end
        end
        return best;
    endfunction

    // Next prefix length on an accepted bit; without overlap a full match restarts from empty.
    always_comb begin
        int unsigned k;
        k       = 32'(state_q);
        state_d = state_q;
        if (!OVERLAP && (state_q == ST_MATCH)) begin
            k = 0;
        end
        if (en) begin
            state_d = kmp_next(k, w);
        end
    end

    // State register: async reset, then synchronous clear, then strobe-qualified update.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_EMPTY;
        end else if (clear) begin
            state_q <= ST_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    assign state = state_q;
    assign z     = (state_q == ST_MATCH);

`ifdef SEQ_DET_COUNT_EN
    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    // Count every accepted edge landing in the match state, saturating at all-ones.
    always_comb begin
        count_d = count_q;
        if (en && (state_d == ST_MATCH) && (count_q != '1)) begin
            count_d = count_q + 1'b1;
        end
    end

    // Counter register shares the state register's reset/clear precedence.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else if (clear) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign match_count = count_q;
`else
    assign match_count = '0;
`endif

endmodule

// File: doc/seq_detector_param.md
# seq_detector_param

Parametrised Moore serial pattern detector. It samples a one-bit serial input `w` on qualified clock edges and asserts `z` while the last `N` accepted bits equal `PATTERN`. It generalises the fixed "two consecutive ones" detector to any pattern of length `N`, with selectable overlapping or non-overlapping matching and an optional saturating hit counter. It sits between a bit-serial source (debounced button, UART bit, shift register) and board LEDs or a control FSM.

## Interface
- `N`, 4: pattern length in bits; legal range 2..16.
- `PATTERN`, 4'b1011: `N`-bit target; `PATTERN[N-1]` is the first bit expected.
- `OVERLAP`, 1: 1 = overlapping matches allowed; 0 = matching restarts from empty after each hit.
- `CW`, 8: width of `match_count`.
- `clk` in 1: clock, rising edge.
- `reset` in 1: asynchronous, active-high; clock `clk`.
- `clear` in 1: synchronous clear of state and counter.
- `en` in 1: sample strobe; `w` is accepted only on edges where `en`=1.
- `w` in 1: serial data bit.
- `z` out 1: Moore match flag, `state == N`.
- `state` out `$clog2(N+1)`: matched-prefix length 0..N, for debug.
- `match_count` out `CW`: saturating count of matches.

## Operation
- State `k` (0..N) means the last accepted bits equal the first `k` bits of `PATTERN`. Reset state is 0.
- On an edge with `en`=1 and `clear`=0, the next state is the longest `j`, with `j <= N`, such that the first `j` pattern bits equal the suffix of (current prefix followed by `w`). This is the KMP failure-function rule.
  - Example for `PATTERN`=1011: state 3 with `w`=0 goes to state 2.
- Non-overlap (`OVERLAP`=0): from state N, the next state is computed as if from state 0.
- Overlap (`OVERLAP`=1): from state N, the next state uses the full prefix of length N. For a pattern of all ones, the block stays in state N while ones continue, matching the original detector.
- When `en`=0, state and counter hold.
- Precedence: `reset` > `clear` > `en`. `clear` forces state 0 and count 0, regardless of `en`.
- `z` is decoded only from the state register. No combinational path from `w` or `en` to any output.
- Counter: increments by 1 on every accepted edge whose next state is N, including N->N. It saturates at 2^CW−1 and never wraps.
- Next-state logic is a combinational function evaluated over `PATTERN` at elaboration. It must not use a shift register plus comparator, because `state` must report prefix length.

## Timing
- After reset: `state`=0, `z`=0, `match_count`=0. These values apply immediately, asynchronously.
- Latency: `z` rises in the cycle after the edge that accepted the final pattern bit.
- `z` stays high until the next accepted edge that leaves state N, or until `clear` or `reset`. Idle `en`=0 cycles keep `z` high.
- `match_count` updates on the same edge that moves `state` to N.
- Reset asserted mid-pattern discards all partial progress. The first accepted bit after release is treated as bit 0.
- `clear` together with `en`=1 and a completing bit: the clear wins, and the count stays 0.

## Configuration
- `SEQ_DET_COUNT_EN` defined: the counter is implemented as described above.
- `SEQ_DET_COUNT_EN` not defined: no counter flops are built, and `match_count` is tied to 0. `z` and `state` behaviour is unchanged.

## Test plan
All scenarios use `N`=4, `PATTERN`=1011, `CW`=8.
- Reset: hold `reset` high for 3 cycles while toggling `w` and `en`. Required: `state`=0, `z`=0, `match_count`=0 throughout.
- Basic match: apply 1,0,1,1 with `en`=1 each cycle. Required:
  - `state` sequence 1,2,3,4.
  - `z`=1 in the cycle after the 4th edge.
  - `match_count`=1.
- Overlap: apply 1,0,1,1,0,1,1.
  - `OVERLAP`=1: `z` pulses after bits 4 and 7, `match_count`=2, and the state after bit 5 is 2.
  - `OVERLAP`=0: a single match, `match_count`=1, and the final state is 1.
- Strobe gaps: apply 1,0,1,1 with `en`=0 for 2 cycles between each bit, then hold `en`=0 for 5 cycles. Required: the match is still detected, and `z` stays high through all 5 idle cycles.
- Saturation (macro defined, `OVERLAP`=1): apply "1" followed by 300 repeats of "011", giving 300 matches. Required: `match_count` stops at 255.
  - Same stimulus with the macro undefined: `match_count` stays 0 throughout, and `z` behaviour is identical.
- Mid-pattern events:
  - Pulse `reset` after the bits 1,0,1. Then apply 1. Required: no match, `state`=1.
  - Assert `clear` together with the completing bit. Required: `state`=0, `z`=0, count unchanged at 0.
